// File: rtl/move_executor_pkg.sv
// Shared types, movement codes and helpers for the 2048-style move executor.
package move_executor_pkg;

    typedef logic [3:0] tile_t;

    localparam logic [2:0] MOV_NONE  = 3'd0;
    localparam logic [2:0] MOV_LEFT  = 3'd1;
    localparam logic [2:0] MOV_RIGHT = 3'd2;
    localparam logic [2:0] MOV_UP    = 3'd3;
    localparam logic [2:0] MOV_DOWN  = 3'd4;

    // Board after reset: cell0 = 1 and cell15 = 1, everything else empty.
    localparam logic [63:0] RESET_BOARD = 64'h1000_0000_0000_0001;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PROC     = 3'd1,
        S_SPAWN    = 3'd2,
        S_DONE     = 3'd3,
        S_WAIT_REL = 3'd4
    } state_t;

    // Tile exponent increment that sticks at 15 instead of wrapping.
    function automatic tile_t sat_inc(input tile_t e);
        return (e == 4'd15) ? 4'd15 : (e + 4'd1);
    endfunction

    // Board cell holding element j of line n; element 0 is the slide target.
    function automatic logic [3:0] cell_idx(input logic [2:0] dir, input logic [1:0] n,
                                            input logic [1:0] j);
        logic [3:0] idx;
        case (dir)
            MOV_LEFT:  idx = {n, j};
            MOV_RIGHT: idx = {n, 2'd3 - j};
            MOV_UP:    idx = {j, n};
            MOV_DOWN:  idx = {2'd3 - j, n};
            default:   idx = {n, j};
        endcase
        return idx;
    endfunction

    // One step of the 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

endpackage

// File: rtl/move_executor_line.sv
// Combinational slide-and-merge of one 4-tile line toward element 0.
module line_merge
    import move_executor_pkg::*;
(
    input  tile_t [3:0] line_i,
    output tile_t [3:0] line_o,
    output logic        changed_o
);

    tile_t [3:0] pack_s;
    tile_t [3:0] merge_s;
    logic  [2:0] pos_a_s;
    logic  [2:0] pos_b_s;
    logic        hit_s;

    // Compress, merge each equal pair once scanning from 0, then recompress.
    always_comb begin
        pack_s  = '0;
        pos_a_s = 3'd0;
        for (int j = 0; j < 4; j++) begin
            pack_s[pos_a_s[1:0]] = (line_i[j] != 4'd0) ? line_i[j] : pack_s[pos_a_s[1:0]];
            pos_a_s = pos_a_s + {2'd0, (line_i[j] != 4'd0)};
        end

        merge_s = pack_s;
        hit_s   = 1'b0;
        for (int j = 0; j < 3; j++) begin
            // A zeroed partner cannot merge again, so each tile merges at most once.
            hit_s          = (merge_s[j] != 4'd0) && (merge_s[j] == merge_s[j+1]);
            merge_s[j]     = hit_s ? sat_inc(merge_s[j]) : merge_s[j];
            merge_s[j+1]   = hit_s ? 4'd0 : merge_s[j+1];
        end

        line_o  = '0;
        pos_b_s = 3'd0;
        for (int j = 0; j < 4; j++) begin
            line_o[pos_b_s[1:0]] = (merge_s[j] != 4'd0) ? merge_s[j] : line_o[pos_b_s[1:0]];
            pos_b_s = pos_b_s + {2'd0, (merge_s[j] != 4'd0)};
        end

        changed_o = (line_o != line_i);
    end

endmodule

// File: rtl/move_executor.sv
// Applies one movement code to the 4x4 board a line per cycle, spawns a tile, pulses flag.
module move_executor #(
    parameter int unsigned WIN_EXP   = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  movement_i,
    output logic        flag_o,
    output logic        busy_o,
    output logic        changed_o,
    output logic        win_o,
    output logic [63:0] board_o
);
    import move_executor_pkg::*;

    localparam tile_t WIN_TILE   = tile_t'(WIN_EXP);
    localparam logic  SPAWN_WINS = (WIN_TILE <= 4'd1);

    state_t       state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [2:0]   dir_q, dir_d;
    tile_t [15:0] board_q, board_d;
    logic         changed_q, changed_d;
    logic         win_q, win_d;
    logic [15:0]  lfsr_q;
    logic         flag_q;
    logic         busy_q;

    tile_t [3:0]  line_in_s;
    tile_t [3:0]  line_out_s;
    logic         line_chg_s;
    logic         line_win_s;
    logic         move_valid_s;
    logic [3:0]   probe_s;
    logic [3:0]   spawn_idx_s;
    logic         spawn_ok_s;

    assign move_valid_s = (movement_i >= MOV_LEFT) && (movement_i <= MOV_DOWN);

    // Gather line idx_q of the board in slide order for the latched direction.
    always_comb begin
        line_in_s = '0;
        for (int j = 0; j < 4; j++) begin
            line_in_s[j] = board_q[cell_idx(dir_q, idx_q, 2'(j))];
        end
        line_win_s = 1'b0;
        for (int j = 0; j < 4; j++) begin
            line_win_s = line_win_s | (line_out_s[j] >= WIN_TILE);
        end
    end

    line_merge u_line_merge (
        .line_i    (line_in_s),
        .line_o    (line_out_s),
        .changed_o (line_chg_s)
    );

    // First empty cell scanning upward from lfsr[3:0], wrapping 15 -> 0.
    always_comb begin
        spawn_ok_s  = 1'b0;
        spawn_idx_s = 4'd0;
        probe_s     = 4'd0;
        for (int k = 0; k < 16; k++) begin
            probe_s = lfsr_q[3:0] + 4'(k);
            if (!spawn_ok_s && (board_q[probe_s] == 4'd0)) begin
                spawn_ok_s  = 1'b1;
                spawn_idx_s = probe_s;
            end else begin
                spawn_ok_s  = spawn_ok_s;
            end
        end
    end

    // Move sequencer: next state, line write-back, spawn and sticky flags.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dir_d     = dir_q;
        board_d   = board_q;
        changed_d = changed_q;
        win_d     = win_q;
        case (state_q)
            S_IDLE: begin
                if (move_valid_s) begin
                    dir_d     = movement_i;
                    idx_d     = 2'd0;
                    changed_d = 1'b0;
                    state_d   = S_PROC;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_PROC: begin
                for (int j = 0; j < 4; j++) begin
                    board_d[cell_idx(dir_q, idx_q, 2'(j))] = line_out_s[j];
                end
                changed_d = changed_q | line_chg_s;
                win_d     = win_q | line_win_s;
                if (idx_q == 2'd3) begin
                    state_d = S_SPAWN;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_PROC;
                end
            end
            S_SPAWN: begin
                if (changed_q && spawn_ok_s) begin
                    board_d[spawn_idx_s] = 4'd1;
                    win_d                = win_q | SPAWN_WINS;
                end else begin
                    board_d = board_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (movement_i == MOV_NONE) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_REL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, board and output registers; the LFSR free-runs outside reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            dir_q     <= MOV_NONE;
            board_q   <= RESET_BOARD;
            changed_q <= 1'b0;
            win_q     <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            flag_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dir_q     <= dir_d;
            board_q   <= board_d;
            changed_q <= changed_d;
            win_q     <= win_d;
            lfsr_q    <= lfsr_next(lfsr_q);
            flag_q    <= (state_d == S_DONE);
            busy_q    <= (state_d == S_PROC) || (state_d == S_SPAWN) || (state_d == S_DONE);
        end
    end

    assign flag_o    = flag_q;
    assign busy_o    = busy_q;
    assign changed_o = changed_q;
    assign win_o     = win_q;
    assign board_o   = board_q;

endmodule

// File: tb/tb_move_executor.sv
// Scoreboard bench for move_executor; win threshold lowered to 3 so it is reachable.
module tb_move_executor;
    import move_executor_pkg::*;

    localparam int          TB_WIN  = 3;
    localparam logic [15:0] TB_SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  movement;
    logic        flag, busy, changed, win;
    logic [63:0] board;

    tile_t [3:0] lm_in, lm_out;
    logic        lm_chg;

    typedef struct {
        logic [63:0] board;
        logic        changed;
        logic        win;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] mb;
    logic        mwin;
    logic [15:0] m_lfsr;
    int          n_chk = 0;
    int          n_err = 0;

    localparam logic [15:0] LM_IN  [9] = '{16'h2211, 16'h1111, 16'h1010, 16'h00FF, 16'h4321,
                                           16'h1000, 16'h0222, 16'h0000, 16'hEE00};
    localparam logic [15:0] LM_EXP [9] = '{16'h0032, 16'h0022, 16'h0002, 16'h000F, 16'h4321,
                                           16'h0001, 16'h0023, 16'h0000, 16'h000F};
    localparam logic        LM_CHG [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    move_executor #(.WIN_EXP(TB_WIN), .LFSR_SEED(TB_SEED)) dut (
        .clk_i(clk), .rst_i(rst), .movement_i(movement), .flag_o(flag),
        .busy_o(busy), .changed_o(changed), .win_o(win), .board_o(board)
    );

    line_merge u_lm (.line_i(lm_in), .line_o(lm_out), .changed_o(lm_chg));

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] n;
        n = {1'b0, l[15:1]};
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Reference LFSR tracking the DUT from reset.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= TB_SEED;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic void model_merge(input logic [2:0] dir, input logic [63:0] bin,
                                        output logic [63:0] bout, output bit chg);
        int idx [4];
        logic [3:0] v [4];
        logic [3:0] o [4];
        int cnt, i, p, r, c;
        bout = bin;
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < 4; j++) begin
                case (dir)
                    MOV_LEFT:  begin r = n;     c = j;     end
                    MOV_RIGHT: begin r = n;     c = 3 - j; end
                    MOV_UP:    begin r = j;     c = n;     end
                    default:   begin r = 3 - j; c = n;     end
                endcase
                idx[j] = r * 4 + c;
                v[j] = 4'd0;
                o[j] = 4'd0;
            end
            cnt = 0;
            for (int j = 0; j < 4; j++) begin
                if (bin[4*idx[j] +: 4] != 4'd0) begin
                    v[cnt] = bin[4*idx[j] +: 4];
                    cnt++;
                end
            end
            i = 0;
            p = 0;
            while (i < cnt) begin
                if (i + 1 < cnt && v[i] == v[i+1]) begin
                    o[p] = (v[i] == 4'd15) ? 4'd15 : v[i] + 4'd1;
                    i += 2;
                end else begin
                    o[p] = v[i];
                    i += 1;
                end
                p++;
            end
            for (int j = 0; j < 4; j++) bout[4*idx[j] +: 4] = o[j];
        end
        chg = (bout != bin);
    endfunction

    function automatic logic [63:0] model_spawn(input logic [63:0] b, input logic [15:0] l);
        logic [63:0] r;
        int id;
        r = b;
        for (int k = 0; k < 16; k++) begin
            id = (int'(l[3:0]) + k) % 16;
            if (r[4*id +: 4] == 4'd0) begin
                r[4*id +: 4] = 4'd1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic int count_nz(input logic [63:0] b);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) if (b[4*i +: 4] != 4'd0) n++;
        return n;
    endfunction

    // Update the reference board for a move starting at the next clock edge and queue it.
    task automatic push_expected(input logic [2:0] dir);
        logic [63:0] nb;
        logic [15:0] l;
        bit chg;
        exp_t e;
        model_merge(dir, mb, nb, chg);
        for (int i = 0; i < 16; i++) if (int'(nb[4*i +: 4]) >= TB_WIN) mwin = 1'b1;
        l = m_lfsr;
        repeat (5) l = lfsr_step(l);
        if (chg) begin
            nb = model_spawn(nb, l);
            if (TB_WIN <= 1) mwin = 1'b1;
        end
        mb = nb;
        e.board = nb;
        e.changed = chg;
        e.win = mwin;
        sb_q.push_back(e);
    endtask

    // Drive one move, check timing and scoreboard result, then hold and release the button.
    task automatic do_move(input logic [2:0] dir, input int hold, input bit toggle);
        int cnt;
        bit seen;
        exp_t e;
        @(negedge clk);
        movement = dir;
        push_expected(dir);
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 12) begin
            @(posedge clk); #1;
            cnt++;
            n_chk++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_in_move cycle %0d: got %b want 1", cnt, busy);
            end
            if (flag === 1'b1) seen = 1'b1;
            else if (toggle) movement = (cnt < 5) ? 3'($urandom_range(0, 7)) : dir;
        end
        n_chk++;
        if (!seen) begin
            n_err++;
            $display("FAIL flag_timeout: no flag within %0d cycles", cnt);
            sb_q.delete();
            return;
        end
        if (cnt != 6) begin
            n_err++;
            $display("FAIL flag_latency: got %0d cycles want 6", cnt);
        end
        movement = dir;
        e = sb_q.pop_front();
        n_chk++;
        if (board !== e.board) begin
            n_err++;
            $display("FAIL board: got %h want %h", board, e.board);
        end
        n_chk++;
        if (changed !== e.changed) begin
            n_err++;
            $display("FAIL changed: got %b want %b", changed, e.changed);
        end
        n_chk++;
        if (win !== e.win) begin
            n_err++;
            $display("FAIL win: got %b want %b", win, e.win);
        end
        for (int h = 0; h < ((hold < 1) ? 1 : hold); h++) begin
            @(posedge clk); #1;
            n_chk++;
            if (flag !== 1'b0 || busy !== 1'b0 || board !== e.board) begin
                n_err++;
                $display("FAIL hold: flag=%b busy=%b board=%h want 0 0 %h", flag, busy, board, e.board);
            end
        end
        movement = MOV_NONE;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        n_chk++;
        if (board !== RESET_BOARD || flag !== 1'b0 || busy !== 1'b0 || changed !== 1'b0 || win !== 1'b0) begin
            n_err++;
            $display("FAIL %s: board=%h flag=%b busy=%b changed=%b win=%b want %h 0 0 0 0",
                     tag, board, flag, busy, changed, win, RESET_BOARD);
        end
    endtask

    task automatic test_line_merge();
        for (int i = 0; i < 9; i++) begin
            lm_in = LM_IN[i];
            #1;
            n_chk++;
            if (lm_out !== LM_EXP[i] || lm_chg !== LM_CHG[i]) begin
                n_err++;
                $display("FAIL line_merge[%0d]: got %h/%b want %h/%b", i, lm_out, lm_chg, LM_EXP[i], LM_CHG[i]);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        movement = MOV_NONE;
        rst = 1'b1;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mb = RESET_BOARD;
        mwin = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_left_hold();
        do_move(MOV_LEFT, 15, 1'b0);
        n_chk++;
        if (board[3:0] !== 4'd1 || board[51:48] !== 4'd1 || count_nz(board) != 3) begin
            n_err++;
            $display("FAIL first_left: board=%h want cell0=1 cell12=1 and 3 tiles", board);
        end
    endtask

    task automatic test_illegal_code();
        @(negedge clk);
        movement = 3'b101;
        repeat (6) begin
            @(posedge clk); #1;
            n_chk++;
            if (busy !== 1'b0 || flag !== 1'b0 || board !== mb) begin
                n_err++;
                $display("FAIL illegal_code: busy=%b flag=%b board=%h want 0 0 %h", busy, flag, board, mb);
            end
        end
        movement = MOV_NONE;
    endtask

    task automatic test_reset_mid_move();
        @(negedge clk);
        movement = MOV_DOWN;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        movement = MOV_NONE;
        #1;
        check_reset_values("reset_mid_proc");
        @(negedge clk);
        rst = 1'b0;
        mb = RESET_BOARD;
        mwin = 1'b0;
        sb_q.delete();
        test_left_hold();
    endtask

    task automatic test_toggle_during_proc();
        do_move(MOV_UP, 2, 1'b1);
        do_move(MOV_RIGHT, 2, 1'b1);
    endtask

    task automatic test_no_change_right();
        logic [63:0] nb;
        logic [63:0] pre;
        bit chg;
        bit found;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            model_merge(MOV_RIGHT, mb, nb, chg);
            pre = mb;
            do_move(MOV_RIGHT, 1, 1'b0);
            if (!chg) begin
                found = 1'b1;
                n_chk++;
                if (board !== pre || changed !== 1'b0) begin
                    n_err++;
                    $display("FAIL no_change: board=%h changed=%b want %h 0", board, changed, pre);
                end
            end
        end
        n_chk++;
        if (!found) begin
            n_err++;
            $display("FAIL no_change_case: not reached within 40 moves");
        end
    endtask

    task automatic test_win();
        logic [2:0] dirs [4];
        int t;
        dirs = '{MOV_LEFT, MOV_UP, MOV_RIGHT, MOV_DOWN};
        test_reset();
        t = 0;
        while (!mwin && t < 80) begin
            do_move(dirs[t % 4], 1, 1'b0);
            t++;
        end
        n_chk++;
        if (win !== 1'b1) begin
            n_err++;
            $display("FAIL win_reached: got %b want 1 after %0d moves", win, t);
        end
        for (int k = 0; k < 3; k++) do_move(dirs[k], 1, 1'b0);
        n_chk++;
        if (win !== 1'b1) begin
            n_err++;
            $display("FAIL win_sticky: got %b want 1", win);
        end
    endtask

    initial begin
        rst = 1'b0;
        movement = MOV_NONE;
        lm_in = '0;
        mb = RESET_BOARD;
        mwin = 1'b0;
        #2;
        test_line_merge();
        test_reset();
        test_left_hold();
        test_illegal_code();
        test_reset_mid_move();
        test_toggle_during_proc();
        test_no_change_right();
        test_win();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
